// File: rtl/rename_regfile_ckpt.sv
// Architectural register file with rename tags (busy + ROB tag) and a bank of
// rename-map checkpoints for selective mispredict recovery.
module rename_regfile_ckpt #(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int ROB_W = 4,
  parameter int NRD   = 2,
  parameter int NCKPT = 4,
  localparam int RID_W = $clog2(NREG),
  localparam int CK_W  = $clog2(NCKPT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic [NRD*RID_W-1:0]  rd_idx,
  output logic [NRD-1:0]        rd_busy,
  output logic [NRD*XLEN-1:0]   rd_data,
  output logic [NRD*ROB_W-1:0]  rd_rob,
  input  logic                  ren_en,
  input  logic [RID_W-1:0]      ren_rd,
  input  logic [ROB_W-1:0]      ren_rob,
  input  logic                  cm_en,
  input  logic [RID_W-1:0]      cm_rd,
  input  logic [XLEN-1:0]       cm_data,
  input  logic [ROB_W-1:0]      cm_rob,
  input  logic                  ck_save,
  output logic [CK_W-1:0]       ck_id,
  output logic                  ck_full,
  input  logic                  ck_free,
  input  logic [CK_W-1:0]       ck_free_id,
  input  logic                  rb_en,
  input  logic [CK_W-1:0]       rb_id,
  input  logic [NCKPT-1:0]      rb_kill,
  input  logic                  flush
);

  logic [XLEN-1:0]  r_data    [NREG];
  logic [NREG-1:0]  r_busy;
  logic [ROB_W-1:0] r_tag     [NREG];
  logic [NCKPT-1:0] r_ck_valid;
  logic [NREG-1:0]  r_ck_busy [NCKPT];
  logic [ROB_W-1:0] r_ck_tag  [NCKPT][NREG];

  logic [NREG-1:0]  w_busy_nx;
  logic [ROB_W-1:0] w_tag_nx     [NREG];
  logic [NCKPT-1:0] w_ck_valid_nx;
  logic [NREG-1:0]  w_ck_busy_nx [NCKPT];
  logic [ROB_W-1:0] w_ck_tag_nx  [NCKPT][NREG];
  logic             w_cm_any;
  logic             w_cm_hit;
  logic [RID_W-1:0] w_idx;

  assign w_cm_any = cm_en && (cm_rd != '0);
  assign w_cm_hit = w_cm_any && r_busy[cm_rd] && (r_tag[cm_rd] == cm_rob);

  // Lowest free slot; reported as 0 when the bank is full.
  always_comb begin
    ck_id = '0;
    for (int i = NCKPT - 1; i >= 0; i--) begin
      if (!r_ck_valid[i]) ck_id = CK_W'(i);
    end
  end
  assign ck_full = &r_ck_valid;

  // Reads see a same-cycle matching commit, never a same-cycle rename.
  always_comb begin
    rd_busy = '0;
    rd_data = '0;
    rd_rob  = '0;
    w_idx   = '0;
    for (int p = 0; p < NRD; p++) begin
      w_idx = rd_idx[p*RID_W +: RID_W];
      if (w_idx == '0) begin
        rd_busy[p] = 1'b0;
      end else if (w_cm_hit && (cm_rd == w_idx)) begin
        rd_busy[p]                 = 1'b0;
        rd_data[p*XLEN +: XLEN]    = cm_data;
        rd_rob[p*ROB_W +: ROB_W]   = '0;
      end else begin
        rd_busy[p]                 = r_busy[w_idx];
        rd_data[p*XLEN +: XLEN]    = r_data[w_idx];
        rd_rob[p*ROB_W +: ROB_W]   = r_tag[w_idx];
      end
    end
  end

  // NOTE: every variable gets its hold value first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    w_busy_nx     = r_busy;
    w_tag_nx      = r_tag;
    w_ck_valid_nx = r_ck_valid;
    w_ck_busy_nx  = r_ck_busy;
    w_ck_tag_nx   = r_ck_tag;

    for (int s = 0; s < NCKPT; s++) begin
      if (w_cm_any && r_ck_valid[s] && r_ck_busy[s][cm_rd] &&
          (r_ck_tag[s][cm_rd] == cm_rob))
        w_ck_busy_nx[s][cm_rd] = 1'b0;
    end

    if (flush) begin
      w_busy_nx     = '0;
      w_ck_valid_nx = '0;
    end else if (rb_en) begin
      // Restored map already carries this cycle's commit via the slot clear.
      if (r_ck_valid[rb_id]) begin
        w_busy_nx = w_ck_busy_nx[rb_id];
        w_tag_nx  = r_ck_tag[rb_id];
      end else if (w_cm_hit) begin
        w_busy_nx[cm_rd] = 1'b0;
      end
      if (ck_free) w_ck_valid_nx[ck_free_id] = 1'b0;
      w_ck_valid_nx        = w_ck_valid_nx & ~rb_kill;
      w_ck_valid_nx[rb_id] = 1'b0;
    end else begin
      if (w_cm_hit) w_busy_nx[cm_rd] = 1'b0;
      if (ren_en && (ren_rd != '0)) begin
        w_busy_nx[ren_rd] = 1'b1;
        w_tag_nx[ren_rd]  = ren_rob;
      end
      if (ck_free) w_ck_valid_nx[ck_free_id] = 1'b0;
      if (ck_save && !ck_full) begin
        w_ck_valid_nx[ck_id] = 1'b1;
        w_ck_busy_nx[ck_id]  = w_busy_nx;
        w_ck_tag_nx[ck_id]   = w_tag_nx;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the data array is reset explicitly because reads of a never
      // committed register must return 0, not an unknown.
      for (int i = 0; i < NREG; i++) begin
        r_data[i] <= '0;
        r_tag[i]  <= '0;
      end
      r_busy     <= '0;
      r_ck_valid <= '0;
      for (int s = 0; s < NCKPT; s++) begin
        r_ck_busy[s] <= '0;
        for (int i = 0; i < NREG; i++) r_ck_tag[s][i] <= '0;
      end
    end else if (rdy) begin
      if (w_cm_hit) r_data[cm_rd] <= cm_data;
      r_busy     <= w_busy_nx;
      r_tag      <= w_tag_nx;
      r_ck_valid <= w_ck_valid_nx;
      r_ck_busy  <= w_ck_busy_nx;
      r_ck_tag   <= w_ck_tag_nx;
    end
  end

endmodule

// File: tb/tb_rename_regfile_ckpt.sv
// Directed bench for rename_regfile_ckpt: bypass, tag mismatch, checkpoint
// save/free/full, rollback with commit on top, flush and rdy gating.
module tb_rename_regfile_ckpt;

  localparam int XLEN = 32, NREG = 32, ROB_W = 4, NRD = 2, NCKPT = 4;
  localparam int RID_W = 5, CK_W = 2;

  logic                 clk = 1'b0;
  logic                 rst, rdy;
  logic [NRD*RID_W-1:0] rd_idx;
  logic [NRD-1:0]       rd_busy;
  logic [NRD*XLEN-1:0]  rd_data;
  logic [NRD*ROB_W-1:0] rd_rob;
  logic                 ren_en;
  logic [RID_W-1:0]     ren_rd;
  logic [ROB_W-1:0]     ren_rob;
  logic                 cm_en;
  logic [RID_W-1:0]     cm_rd;
  logic [XLEN-1:0]      cm_data;
  logic [ROB_W-1:0]     cm_rob;
  logic                 ck_save;
  logic [CK_W-1:0]      ck_id;
  logic                 ck_full;
  logic                 ck_free;
  logic [CK_W-1:0]      ck_free_id;
  logic                 rb_en;
  logic [CK_W-1:0]      rb_id;
  logic [NCKPT-1:0]     rb_kill;
  logic                 flush;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rename_regfile_ckpt #(
    .XLEN(XLEN), .NREG(NREG), .ROB_W(ROB_W), .NRD(NRD), .NCKPT(NCKPT)
  ) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .rd_idx(rd_idx), .rd_busy(rd_busy), .rd_data(rd_data), .rd_rob(rd_rob),
    .ren_en(ren_en), .ren_rd(ren_rd), .ren_rob(ren_rob),
    .cm_en(cm_en), .cm_rd(cm_rd), .cm_data(cm_data), .cm_rob(cm_rob),
    .ck_save(ck_save), .ck_id(ck_id), .ck_full(ck_full),
    .ck_free(ck_free), .ck_free_id(ck_free_id),
    .rb_en(rb_en), .rb_id(rb_id), .rb_kill(rb_kill), .flush(flush)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    ren_en = 0; ren_rd = '0; ren_rob = '0;
    cm_en = 0; cm_rd = '0; cm_data = '0; cm_rob = '0;
    ck_save = 0; ck_free = 0; ck_free_id = '0;
    rb_en = 0; rb_id = '0; rb_kill = '0; flush = 0;
  endtask

  // Apply current inputs for one edge, then return all controls to idle.
  task automatic step();
    @(posedge clk);
    #1;
    idle();
    #1;
  endtask

  task automatic rd(input logic [RID_W-1:0] a, input logic [RID_W-1:0] b);
    rd_idx = {b, a};
    #1;
  endtask

  task automatic rename(input logic [RID_W-1:0] r, input logic [ROB_W-1:0] t);
    ren_en = 1; ren_rd = r; ren_rob = t;
  endtask

  task automatic commit(input logic [RID_W-1:0] r, input logic [ROB_W-1:0] t,
                        input logic [XLEN-1:0] d);
    cm_en = 1; cm_rd = r; cm_rob = t; cm_data = d;
  endtask

  initial begin
    rst = 1; rdy = 1; rd_idx = '0;
    idle();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    #1;

    // Reset state
    rd(5, 0);
    check("rst_busy", 64'(rd_busy), 64'd0);
    check("rst_data", 64'(rd_data), 64'd0);
    check("rst_rob",  64'(rd_rob),  64'd0);
    check("rst_ckid", 64'(ck_id),   64'd0);
    check("rst_full", 64'(ck_full), 64'd0);

    // Rename then commit with bypass
    rename(3, 6); step();
    rd(3, 3);
    check("ren_busy", 64'(rd_busy[0]), 64'd1);
    check("ren_rob",  64'(rd_rob[3:0]), 64'd6);
    commit(3, 6, 32'hDEADBEEF); #1;
    check("byp_busy",  64'(rd_busy), 64'd0);
    check("byp_data0", 64'(rd_data[31:0]),  64'hDEADBEEF);
    check("byp_data1", 64'(rd_data[63:32]), 64'hDEADBEEF);
    check("byp_rob",   64'(rd_rob), 64'd0);
    step();
    check("cm_busy", 64'(rd_busy[0]), 64'd0);
    check("cm_data", 64'(rd_data[31:0]), 64'hDEADBEEF);

    // Stale commit: younger rename owns x3
    rename(3, 6); step();
    rename(3, 9); step();
    commit(3, 6, 32'h1234); #1;
    check("stale_byp_busy", 64'(rd_busy[0]), 64'd1);
    check("stale_byp_data", 64'(rd_data[31:0]), 64'hDEADBEEF);
    step();
    check("stale_busy", 64'(rd_busy[0]), 64'd1);
    check("stale_rob",  64'(rd_rob[3:0]), 64'd9);
    check("stale_data", 64'(rd_data[31:0]), 64'hDEADBEEF);

    // Checkpoint with same-cycle rename, later rollback
    rd(4, 4);
    check("ck0_id", 64'(ck_id), 64'd0);
    rename(4, 2); ck_save = 1; step();
    check("ck0_id_after", 64'(ck_id), 64'd1);
    rename(4, 5); step();
    check("x4_rob5", 64'(rd_rob[3:0]), 64'd5);
    rb_en = 1; rb_id = 0; step();
    check("rb_x4_busy", 64'(rd_busy[0]), 64'd1);
    check("rb_x4_rob",  64'(rd_rob[3:0]), 64'd2);
    check("rb_ckid",    64'(ck_id), 64'd0);
    check("rb_full",    64'(ck_full), 64'd0);

    // Fill every slot
    for (int i = 0; i < NCKPT; i++) begin
      check("fill_id", 64'(ck_id), 64'(i));
      ck_save = 1; step();
    end
    check("full", 64'(ck_full), 64'd1);
    rd(8, 8);
    rename(8, 3); ck_save = 1; step();
    check("full_hold", 64'(ck_full), 64'd1);
    check("x8_busy",   64'(rd_busy[0]), 64'd1);
    ck_free = 1; ck_free_id = 2; step();
    check("free_id",   64'(ck_id), 64'd2);
    check("free_full", 64'(ck_full), 64'd0);
    // Slot 0 must not have been overwritten by the ignored save
    rb_en = 1; rb_id = 0; step();
    check("nosave_x8", 64'(rd_busy[0]), 64'd0);
    check("nosave_id", 64'(ck_id), 64'd0);

    // Commit clears a checkpointed busy bit
    flush = 1; step();
    check("flush_id", 64'(ck_id), 64'd0);
    ck_save = 1; step();
    rd(7, 7);
    check("x7_ckid", 64'(ck_id), 64'd1);
    rename(7, 1); ck_save = 1; step();
    commit(7, 1, 32'h55); step();
    rename(7, 12); step();
    check("x7_rebusy", 64'(rd_busy[0]), 64'd1);
    rb_en = 1; rb_id = 1; rb_kill = 4'b0001; step();
    check("rbcm_busy", 64'(rd_busy[0]), 64'd0);
    check("rbcm_data", 64'(rd_data[31:0]), 64'h55);
    check("rbcm_id",   64'(ck_id), 64'd0);
    check("rbcm_full", 64'(ck_full), 64'd0);

    // Flush beats rollback; commit data still lands
    rename(9, 7); ck_save = 1; step();
    rename(10, 8); step();
    rd(9, 10);
    check("pre_flush_busy", 64'(rd_busy), 64'd3);
    flush = 1; rb_en = 1; rb_id = 0; commit(10, 8, 32'hA5A5); step();
    check("fl_busy",  64'(rd_busy), 64'd0);
    check("fl_data",  64'(rd_data[63:32]), 64'hA5A5);
    check("fl_ckid",  64'(ck_id), 64'd0);
    check("fl_full",  64'(ck_full), 64'd0);

    // rdy gating and x0 immunity
    rd(11, 0);
    rdy = 0; rename(11, 4); step();
    rdy = 1;
    check("rdy_hold", 64'(rd_busy[0]), 64'd0);
    rename(0, 3); step();
    check("x0_busy", 64'(rd_busy[1]), 64'd0);
    check("x0_rob",  64'(rd_rob[7:4]), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
